// File: rtl/sub_sequence_generator.sv
// Serial frame generator: M repetitions of (N ones, N zeros), with start
// validation, abort and a one-cycle completion pulse.
module sub_sequence_generator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] N,
  input  logic [4:0] M,
  output logic       data_out,
  output logic       data_vld,
  output logic       busy,
  output logic       done_pulse,
  output logic       err_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND1 = 2'd1,
    SEND0 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [5:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [4:0] r_rep_cnt, w_rep_cnt_nxt;
  logic [5:0] r_n_lat, w_n_lat_nxt;
  logic [4:0] r_m_lat, w_m_lat_nxt;
  logic       r_err, w_err_nxt;
  logic       w_last_bit;
  logic       w_last_rep;

  // Latched N and M are never zero while sending, so these cannot underflow.
  assign w_last_bit = (r_bit_cnt == r_n_lat - 6'd1);
  assign w_last_rep = (r_rep_cnt == r_m_lat - 5'd1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_rep_cnt_nxt = r_rep_cnt;
    w_n_lat_nxt   = r_n_lat;
    w_m_lat_nxt   = r_m_lat;
    w_err_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          if ((N != 6'd0) && (M != 5'd0)) begin
            w_state_nxt   = SEND1;
            w_bit_cnt_nxt = 6'd0;
            w_rep_cnt_nxt = 5'd0;
            w_n_lat_nxt   = N;
            w_m_lat_nxt   = M;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      SEND1: begin
        if (abort) begin
          w_state_nxt   = IDLE;
          w_bit_cnt_nxt = 6'd0;
          w_rep_cnt_nxt = 5'd0;
        end else if (w_last_bit) begin
          w_state_nxt   = SEND0;
          w_bit_cnt_nxt = 6'd0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 6'd1;
        end
      end

      SEND0: begin
        if (abort) begin
          w_state_nxt   = IDLE;
          w_bit_cnt_nxt = 6'd0;
          w_rep_cnt_nxt = 5'd0;
        end else if (w_last_bit) begin
          w_bit_cnt_nxt = 6'd0;
          if (w_last_rep) begin
            w_state_nxt   = DONE;
            w_rep_cnt_nxt = 5'd0;
          end else begin
            w_state_nxt   = SEND1;
            w_rep_cnt_nxt = r_rep_cnt + 5'd1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 6'd1;
        end
      end

      // The pulse is already registered; abort here cannot retract it.
      DONE: w_state_nxt = IDLE;

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= 6'd0;
      r_rep_cnt <= 5'd0;
      r_n_lat   <= 6'd0;
      r_m_lat   <= 5'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_n_lat   <= w_n_lat_nxt;
      r_m_lat   <= w_m_lat_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // All outputs come straight from registers, so reset clears them at once.
  assign data_vld   = (r_state == SEND1) || (r_state == SEND0);
  assign data_out   = (r_state == SEND1);
  assign busy       = (r_state != IDLE);
  assign done_pulse = (r_state == DONE);
  assign err_pulse  = r_err;

endmodule

// File: doc/sub_sequence_generator.md
SUB_SEQUENCE_GENERATOR -- requirements
Module: sub_sequence_generator

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port start  input  1  one-cycle request to begin a frame.
REQ-004 SHALL have port abort  input  1  terminate the current frame immediately.
REQ-005 SHALL have port N  input  6  run length of each ones-run and each zeros-run of sub-sequence A.
REQ-006 SHALL have port M  input  5  number of A repetitions per frame.
REQ-007 SHALL have port data_out  output  1  serial pattern bit, meaningful only when data_vld=1.
REQ-008 SHALL have port data_vld  output  1  data_out carries a frame bit this cycle.
REQ-009 SHALL have port busy  output  1  frame in progress; start ignored.
REQ-010 SHALL have port done_pulse  output  1  one-cycle pulse after the last bit of a completed frame.
REQ-011 SHALL have port err_pulse  output  1  one-cycle pulse when start is rejected for N=0 or M=0.

Function
REQ-012 SHALL generate frame = M repetitions of A, where A = N ones followed by N zeros; 2*N*M valid bits total.
REQ-013 SHALL implement an FSM with states IDLE, SEND1, SEND0, DONE; all outputs registered or decoded from registered state only.
REQ-014 SHALL accept start only in IDLE; start in SEND1, SEND0 or DONE SHALL be ignored with no side effect.
REQ-015 SHALL latch N and M at start acceptance; N and M changes during the frame SHALL have no effect.
REQ-016 IDLE with start=1, abort=0, N>0, M>0 SHALL go to SEND1 with bit counter=0 and repetition counter=0.
REQ-017 IDLE with start=1, abort=0 and (N=0 or M=0) SHALL stay IDLE and assert err_pulse for exactly the next cycle.
REQ-018 Latency: first data bit (data_vld=1, data_out=1) SHALL appear in the cycle immediately after the start cycle.
REQ-019 data_vld SHALL be 1 in SEND1 and SEND0 only; data_out SHALL be 1 in SEND1 and 0 otherwise.
REQ-020 6-bit bit counter SHALL count 0..N_lat-1 per run; at N_lat-1 it SHALL reset to 0 and the state SHALL change phase.
REQ-021 SEND1 at last bit SHALL go to SEND0.
REQ-022 SEND0 at last bit with repetition counter = M_lat-1 SHALL go to DONE; otherwise it SHALL increment the 5-bit repetition counter and go to SEND1.
REQ-023 Counters SHALL never wrap: max N=63 and M=31 SHALL fit without overflow, giving 3906 valid cycles.
REQ-024 DONE SHALL last exactly one cycle with done_pulse=1, then go to IDLE; the earliest next start is accepted in that IDLE cycle.
REQ-025 busy SHALL be 1 in SEND1, SEND0 and DONE; 0 in IDLE.
REQ-026 abort=1 in SEND1 or SEND0 SHALL force IDLE next cycle and clear both counters; data_vld=0 from that cycle; no done_pulse.
REQ-027 abort and start both high in IDLE: abort SHALL win; start SHALL be ignored and no err_pulse issued.
REQ-028 abort in DONE SHALL not suppress the already-asserted done_pulse.

Reset
REQ-029 On rst_n=0, SHALL enter IDLE asynchronously, clear counters and latched N/M, and set data_out=0, data_vld=0, busy=0, done_pulse=0, err_pulse=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no done_pulse; after release the block SHALL be IDLE and accept start.

Verification
REQ-031 SHALL verify N=2, M=3, start at cycle 0: data_out over cycles 1..12 = 110011001100 with data_vld=1; done_pulse=1 at cycle 13 only; busy=0 at cycle 14.
REQ-032 SHALL verify N=1, M=1: bits 1,0 at cycles 1..2; done_pulse at cycle 3.
REQ-033 SHALL verify start with N=0, M=5 and start with N=4, M=0: err_pulse=1 for one cycle each, data_vld and busy stay 0.
REQ-034 SHALL verify N=3, M=2 with abort at cycle 5: data_vld=0 from cycle 6, no done_pulse, and a new start at cycle 8 gives a correct full frame.
REQ-035 SHALL verify N=4, M=2, with start re-pulsed and N/M changed to 1/1 at cycle 3: output is unchanged, 16 valid bits, one done_pulse.
REQ-036 SHALL verify N=63, M=31: 3906 consecutive valid bits; rst_n dropped mid-frame in a second run gives all outputs 0 immediately.
